// File: rtl/md5_pkg.sv
// Shared MD5 constants, state encoding and message-word index helper for md5_block_engine.
package md5_pkg;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;
  localparam logic [127:0] IV_DIGEST = {IV_D, IV_C, IV_B, IV_A};

  localparam logic [31:0] K [0:63] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [4:0] S [0:63] = '{
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9, 5'd14, 5'd20, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd5, 5'd9, 5'd14, 5'd20, 5'd5, 5'd9, 5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
    5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
  };

  typedef enum logic [1:0] {IDLE, CRUNCH, FINAL, DONE} md5_state_e;

  // Message word consumed by step i; only the low nibble matters because g is taken mod 16.
  function automatic logic [3:0] g_index(input logic [5:0] i);
    logic [3:0] g;
    case (i[5:4])
      2'd0:    g = i[3:0];
      2'd1:    g = i[3:0] * 4'd5 + 4'd1;
      2'd2:    g = i[3:0] * 4'd3 + 4'd5;
      default: g = i[3:0] * 4'd7;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/md5_step.sv
// One combinational MD5 step: round function, add chain and left rotate.
module md5_step
  import md5_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [5:0]  i,
  input  logic [31:0] mword,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next
);

  logic [31:0] f;
  logic [31:0] sum;
  logic [63:0] rot2;

  always_comb begin
    f = '0;
    unique case (i[5:4])
      2'd0: f = (b & c) | (~b & d);
      2'd1: f = (d & b) | (~d & c);
      2'd2: f = b ^ c ^ d;
      2'd3: f = c ^ (b | ~d);
    endcase
    sum    = a + f + K[i] + mword;
    // Rotate via a doubled word; the upper half is rotl(sum, S[i]).
    rot2   = {sum, sum} << S[i];
    a_next = d;
    b_next = b + rot2[63:32];
    c_next = b;
    d_next = c;
  end

endmodule

// File: rtl/md5_block_engine.sv
// MD5 compression of one 512-bit block, ROUNDS_PER_CYCLE steps per clock, with chaining.
// Optional target compare enabled by defining MD5_TARGET_MATCH_EN.
module md5_block_engine
  import md5_pkg::*;
#(
  parameter int unsigned  ROUNDS_PER_CYCLE = 1,
  parameter logic [127:0] INIT_DIGEST      = IV_DIGEST
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_chain,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef MD5_TARGET_MATCH_EN
  input  logic [127:0] target,
  output logic         match,
`endif
  output logic [127:0] out_digest
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds
    $error("md5_block_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam int unsigned LOG2R    = $clog2(ROUNDS_PER_CYCLE);
  localparam logic [5:0]  CNT_LAST = 6'(64 / ROUNDS_PER_CYCLE - 1);

  md5_state_e    state_q, state_d;
  logic [5:0]    cnt_q;
  logic [511:0]  msg_q;
  logic [31:0]   a_q, b_q, c_q, d_q;
  logic [127:0]  chain_q;
  logic [127:0]  start_q;
  logic          accept;
  logic [127:0]  start_sel;
  logic [127:0]  digest_sum;
  logic [5:0]    step_base;

  logic [31:0] sa [ROUNDS_PER_CYCLE+1];
  logic [31:0] sb [ROUNDS_PER_CYCLE+1];
  logic [31:0] sc [ROUNDS_PER_CYCLE+1];
  logic [31:0] sd [ROUNDS_PER_CYCLE+1];

  assign accept    = in_valid & in_ready;
  assign start_sel = in_chain ? chain_q : INIT_DIGEST;
  assign step_base = cnt_q << LOG2R;

  assign sa[0] = a_q;
  assign sb[0] = b_q;
  assign sc[0] = c_q;
  assign sd[0] = d_q;

  for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_step
    logic [5:0]  idx;
    logic [31:0] mword;
    assign idx   = step_base + 6'(r);
    assign mword = msg_q[{g_index(idx), 5'd0} +: 32];

    md5_step u_step (
      .a      (sa[r]),
      .b      (sb[r]),
      .c      (sc[r]),
      .d      (sd[r]),
      .i      (idx),
      .mword  (mword),
      .a_next (sa[r+1]),
      .b_next (sb[r+1]),
      .c_next (sc[r+1]),
      .d_next (sd[r+1])
    );
  end

  assign digest_sum = {start_q[127:96] + d_q, start_q[95:64] + c_q,
                       start_q[63:32]  + b_q, start_q[31:0]  + a_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (in_valid) state_d = CRUNCH;
      CRUNCH: if (cnt_q == CNT_LAST) state_d = FINAL;
      FINAL:  state_d = DONE;
      DONE:   if (out_ready) state_d = in_valid ? CRUNCH : IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      msg_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      d_q        <= '0;
      chain_q    <= INIT_DIGEST;
      start_q    <= INIT_DIGEST;
      out_digest <= '0;
      out_valid  <= 1'b0;
    end else if (accept) begin
      msg_q                  <= in_block;
      start_q                <= start_sel;
      {d_q, c_q, b_q, a_q}   <= start_sel;
      cnt_q                  <= '0;
      out_valid              <= 1'b0;
    end else begin
      unique case (state_q)
        CRUNCH: begin
          a_q   <= sa[ROUNDS_PER_CYCLE];
          b_q   <= sb[ROUNDS_PER_CYCLE];
          c_q   <= sc[ROUNDS_PER_CYCLE];
          d_q   <= sd[ROUNDS_PER_CYCLE];
          cnt_q <= cnt_q + 6'd1;
        end
        FINAL: begin
          chain_q    <= digest_sum;
          out_digest <= digest_sum;
          out_valid  <= 1'b1;
        end
        DONE:    if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef MD5_TARGET_MATCH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      match <= 1'b0;
    end else if (accept) begin
      match <= 1'b0;
    end else if (state_q == FINAL) begin
      match <= (digest_sum == target);
    end else if (state_q == DONE && out_ready) begin
      match <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_md5_block_engine.sv
// Directed bench for md5_block_engine across all legal ROUNDS_PER_CYCLE values.
module tb_md5_block_engine;

  localparam logic [127:0] DIG_EMPTY = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
  localparam logic [127:0] DIG_ABC   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;
  localparam logic [127:0] DIG_A64   = 128'h67733f79_63034a5a_4971b580_d4424801;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [511:0] in_block = '0;
  logic         in_chain = 1'b0;
  logic [4:0]   in_valid = '0;
  logic [4:0]   out_ready = '0;
  logic [4:0]   in_ready;
  logic [4:0]   out_valid;
  logic [127:0] out_digest [5];
  logic [127:0] target = '0;
  logic [4:0]   match;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 5; k++) begin : g_dut
    md5_block_engine #(.ROUNDS_PER_CYCLE(1 << k)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[k]),
      .in_ready   (in_ready[k]),
      .in_block   (in_block),
      .in_chain   (in_chain),
      .out_valid  (out_valid[k]),
      .out_ready  (out_ready[k]),
`ifdef MD5_TARGET_MATCH_EN
      .target     (target),
      .match      (match[k]),
`endif
      .out_digest (out_digest[k])
    );
`ifndef MD5_TARGET_MATCH_EN
    assign match[k] = 1'b0;
`endif
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge; returns one negedge after the accept edge.
  task automatic present(input int k, input logic [511:0] blk, input logic ch);
    int n;
    n = 0;
    while (!in_ready[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_before_accept_k%0d", k), 128'(in_ready[k]), 128'd1);
    in_block    = blk;
    in_chain    = ch;
    in_valid[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid[k] = 1'b0;
  endtask

  // Counts clock edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_done(input int k, output int cycles);
    cycles = 1;
    while (!out_valid[k] && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic drain(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[k] = 1'b0;
    check($sformatf("valid_after_drain_k%0d", k), 128'(out_valid[k]), 128'd0);
  endtask

  initial begin
    logic [511:0] blk_empty, blk_abc, blk_a64, blk_pad;
    int cyc;

    blk_empty         = '0;
    blk_empty[31:0]   = 32'h00000080;
    blk_abc           = '0;
    blk_abc[31:0]     = 32'h80636261;
    blk_abc[479:448]  = 32'h00000018;
    blk_a64           = {16{32'h61616161}};
    blk_pad           = '0;
    blk_pad[31:0]     = 32'h00000080;
    blk_pad[479:448]  = 32'h00000200;

    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rst_in_ready_k%0d", k), 128'(in_ready[k]), 128'd1);
      check($sformatf("rst_out_valid_k%0d", k), 128'(out_valid[k]), 128'd0);
      check($sformatf("rst_out_digest_k%0d", k), out_digest[k], 128'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Empty message at one step per clock.
    present(0, blk_empty, 1'b0);
    wait_done(0, cyc);
    check("empty_latency_r1", 128'(cyc), 128'd66);
    check("empty_digest_r1", out_digest[0], DIG_EMPTY);
    drain(0);

    // "abc" on every rounds-per-cycle build.
    for (int k = 0; k < 5; k++) begin
      present(k, blk_abc, 1'b0);
      wait_done(k, cyc);
      check($sformatf("abc_latency_r%0d", 1 << k), 128'(cyc), 128'(64 / (1 << k) + 2));
      check($sformatf("abc_digest_r%0d", 1 << k), out_digest[k], DIG_ABC);
      drain(k);
    end

    // Two-block chained message: 64 'a' bytes, then padding.
    present(2, blk_a64, 1'b0);
    wait_done(2, cyc);
    drain(2);
    present(2, blk_pad, 1'b1);
    wait_done(2, cyc);
    check("chain_latency_r4", 128'(cyc), 128'd18);
    check("chain_digest_r4", out_digest[2], DIG_A64);
    drain(2);

    // Back-pressure in DONE, then back-to-back accept on release.
    present(1, blk_abc, 1'b0);
    wait_done(1, cyc);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid[1]), 128'd1);
      check("bp_out_digest", out_digest[1], DIG_ABC);
      check("bp_in_ready", 128'(in_ready[1]), 128'd0);
    end
    out_ready[1] = 1'b1;
    in_block     = blk_empty;
    in_chain     = 1'b0;
    in_valid[1]  = 1'b1;
    #1;
    check("bp_release_in_ready", 128'(in_ready[1]), 128'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b0;
    check("bp_accept_valid_fell", 128'(out_valid[1]), 128'd0);
    check("bp_accept_crunching", 128'(in_ready[1]), 128'd0);
    wait_done(1, cyc);
    check("bp_next_latency_r2", 128'(cyc), 128'd34);
    check("bp_next_digest_r2", out_digest[1], DIG_EMPTY);
    drain(1);

    // Reset partway through a block; chain registers must return to the IV.
    present(0, blk_abc, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid[0]), 128'd0);
    check("midrst_in_ready", 128'(in_ready[0]), 128'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("postrst_out_valid", 128'(out_valid[0]), 128'd0);
    check("postrst_in_ready", 128'(in_ready[0]), 128'd1);
    present(0, blk_empty, 1'b1);
    wait_done(0, cyc);
    check("postrst_chain_latency", 128'(cyc), 128'd66);
    check("postrst_chain_digest", out_digest[0], DIG_EMPTY);
    drain(0);

`ifdef MD5_TARGET_MATCH_EN
    target = DIG_ABC;
    present(2, blk_abc, 1'b0);
    wait_done(2, cyc);
    check("match_hit", 128'(match[2]), 128'd1);
    drain(2);
    check("match_cleared", 128'(match[2]), 128'd0);
    target = DIG_ABC ^ 128'd1;
    present(2, blk_abc, 1'b0);
    wait_done(2, cyc);
    check("match_miss", 128'(match[2]), 128'd0);
    check("match_miss_valid", 128'(out_valid[2]), 128'd1);
    drain(2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
